branch_target_buffer: RTL and testbench

- Fetch-stage branch predictor that sits directly upstream of the next-PC selector.
- Each cycle it looks up PCF combinationally and drives BranchPredictedF, BranchPredictedTakenF and BranchPredictedTargetF to that selector.
- It is trained from the EX stage with each resolved conditional branch: PC, actual outcome and computed target.
- It keeps 2-bit saturating counters per entry, plus branch and mispredict statistics counters.

---
 rtl/branch_target_buffer_pkg.sv | 8 +
 rtl/branch_target_buffer_sat_counter2.sv | 10 +
 rtl/branch_target_buffer.sv | 70 +++++++
 tb/tb_branch_target_buffer.sv | 97 +++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: shared counter encodings and table geometry for the BTB.
package branch_target_buffer_pkg;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} cnt_e;
  localparam int DEF_IDX_W = 6;
  localparam int TAG_W = 30 - DEF_IDX_W;
  localparam int ENTRIES = 1 << DEF_IDX_W;
  localparam logic [1:0] CNT_INIT = WT;
endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter given a taken bit.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] nxt
);
  always_comb nxt = taken ? ((cnt == ST) ? ST : cnt + 2'd1) : ((cnt == SNT) ? SNT : cnt - 2'd1);
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters, async lookup, EX-stage training.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int         IDX_W    = DEF_IDX_W,
  parameter logic [1:0] CNT_INIT = branch_target_buffer_pkg::CNT_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        BranchPredictedF,
  output logic        BranchPredictedTakenF,
  output logic [31:0] BranchPredictedTargetF,
  input  logic [31:0] PCE,
  input  logic        BrInstE,
  input  logic        StallE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        BranchPredictedE,
  input  logic        BranchPredictedTakenE,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
);
  localparam int TW = 30 - IDX_W;
  localparam int N  = 1 << IDX_W;
  logic [N-1:0]  valid;
  logic [TW-1:0] tag_q [N];
  logic [31:0]   tgt_q [N];
  logic [1:0]    cnt_q [N];
  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TW-1:0]    f_tag, e_tag;
  logic             hit_f, hit_e, upd, mispred;
  logic [1:0]       cnt_nxt;
  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign hit_f = valid[f_idx] && (tag_q[f_idx] == f_tag);
  assign hit_e = valid[e_idx] && (tag_q[e_idx] == e_tag);
  assign upd = BrInstE & ~StallE;
  assign mispred = upd & ((BranchPredictedE & BranchPredictedTakenE) != BranchE);
  assign BranchPredictedF = hit_f;
  assign BranchPredictedTakenF = hit_f & cnt_q[f_idx][1];
  assign BranchPredictedTargetF = hit_f ? tgt_q[f_idx] : 32'b0;
  sat_counter2 u_sat (.cnt(cnt_q[e_idx]), .taken(BranchE), .nxt(cnt_nxt));
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      BrCount <= '0;
      MispredCount <= '0;
    end else if (upd) begin
      BrCount <= BrCount + 32'd1;
      if (mispred) MispredCount <= MispredCount + 32'd1;
      if (!hit_e && BranchE) valid[e_idx] <= 1'b1;
    end
  end
  // Payload storage has no reset; valid bits alone gate its visibility.
  always_ff @(posedge clk) begin
    if (!rst && upd) begin
      if (hit_e) begin
        cnt_q[e_idx] <= cnt_nxt;
        if (BranchE) tgt_q[e_idx] <= BranchTarget;
      end else if (BranchE) begin
        tag_q[e_idx] <= e_tag;
        tgt_q[e_idx] <= BranchTarget;
        cnt_q[e_idx] <= CNT_INIT;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven directed checks of lookup, training, counters and reset.
module tb_branch_target_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pcf = '0, pce = '0, bt = '0;
  logic br = 0, st = 0, be = 0, bpe = 0, bpte = 0;
  logic hit, tk;
  logic [31:0] tgt, brc, mis;
  int checks = 0, failures = 0;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .PCF(pcf),
    .BranchPredictedF(hit), .BranchPredictedTakenF(tk), .BranchPredictedTargetF(tgt),
    .PCE(pce), .BrInstE(br), .StallE(st), .BranchE(be), .BranchTarget(bt),
    .BranchPredictedE(bpe), .BranchPredictedTakenE(bpte),
    .BrCount(brc), .MispredCount(mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic br, st, be, bpe, bpte;
    logic [31:0] pce, bt;
    logic hit, tk;
    logic [31:0] tgt, brc, mis;
  } vec_t;

  vec_t v [21];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=0x%08h exp=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic h, input logic t, input logic [31:0] g,
                           input logic [31:0] bc, input logic [31:0] mc);
    chk("hit", idx, {31'b0, hit}, {31'b0, h});
    chk("taken", idx, {31'b0, tk}, {31'b0, t});
    chk("target", idx, tgt, g);
    chk("brcount", idx, brc, bc);
    chk("mispred", idx, mis, mc);
  endtask

  initial begin
    //        pcf      br st be bpe bpte pce        bt         hit tk tgt        brc mis
    v[0]  = '{32'h040, 0, 0, 0, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 0, 0};
    v[1]  = '{32'h040, 1, 0, 1, 0, 0, 32'h040, 32'h100, 0, 0, 32'h000, 0, 0};
    v[2]  = '{32'h040, 1, 0, 1, 1, 1, 32'h040, 32'h100, 1, 1, 32'h100, 1, 1};
    v[3]  = '{32'h040, 1, 0, 1, 1, 1, 32'h040, 32'h100, 1, 1, 32'h100, 2, 1};
    v[4]  = '{32'h040, 1, 0, 0, 1, 1, 32'h040, 32'h999, 1, 1, 32'h100, 3, 1};
    v[5]  = '{32'h040, 1, 0, 0, 1, 1, 32'h040, 32'h999, 1, 1, 32'h100, 4, 2};
    v[6]  = '{32'h040, 1, 0, 0, 1, 0, 32'h040, 32'h999, 1, 0, 32'h100, 5, 3};
    v[7]  = '{32'h040, 1, 0, 0, 1, 0, 32'h040, 32'h999, 1, 0, 32'h100, 6, 3};
    v[8]  = '{32'h040, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 0, 32'h100, 7, 3};
    v[9]  = '{32'h040, 1, 0, 1, 1, 0, 32'h040, 32'h104, 1, 0, 32'h100, 7, 3};
    v[10] = '{32'h040, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 0, 32'h104, 8, 4};
    v[11] = '{32'h140, 1, 0, 1, 0, 0, 32'h140, 32'h300, 0, 0, 32'h000, 8, 4};
    v[12] = '{32'h040, 0, 0, 0, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 9, 5};
    v[13] = '{32'h140, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 1, 32'h300, 9, 5};
    v[14] = '{32'h140, 1, 0, 0, 0, 0, 32'h240, 32'h700, 1, 1, 32'h300, 9, 5};
    v[15] = '{32'h142, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 1, 32'h300, 10, 5};
    v[16] = '{32'h240, 0, 0, 0, 0, 0, 32'h000, 32'h000, 0, 0, 32'h000, 10, 5};
    v[17] = '{32'h080, 1, 0, 1, 0, 0, 32'h080, 32'h500, 0, 0, 32'h000, 10, 5};
    v[18] = '{32'h080, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 1, 32'h500, 11, 6};
    v[19] = '{32'h080, 1, 1, 0, 1, 1, 32'h080, 32'h600, 1, 1, 32'h500, 11, 6};
    v[20] = '{32'h080, 0, 0, 0, 0, 0, 32'h000, 32'h000, 1, 1, 32'h500, 11, 6};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = 1'b0;
      pcf = v[i].pcf; br = v[i].br; st = v[i].st; be = v[i].be;
      bpe = v[i].bpe; bpte = v[i].bpte; pce = v[i].pce; bt = v[i].bt;
      #1 check_out(i, v[i].hit, v[i].tk, v[i].tgt, v[i].brc, v[i].mis);
    end
    // Reset coincident with a taken update on a trained entry: the update must be lost.
    @(negedge clk);
    rst = 1'b1; br = 1; st = 0; be = 1; bpe = 0; bpte = 0; pce = 32'h040; bt = 32'h100; pcf = 32'h040;
    @(negedge clk);
    rst = 1'b0; br = 0;
    #1 check_out(100, 0, 0, 32'h0, 0, 0);
    pcf = 32'h080;
    #1 check_out(101, 0, 0, 32'h0, 0, 0);
    // First update after reset proceeds normally.
    @(negedge clk);
    br = 1; be = 1; pce = 32'h040; bt = 32'h220; pcf = 32'h040;
    #1 check_out(102, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    br = 0;
    #1 check_out(103, 1, 1, 32'h220, 1, 1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
